// File: rtl/fetch_queue_if.sv
// Fetch/icache/decode signal bundle for fetch_queue.
interface fetch_queue_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [63:0] inst_rdata;
   logic [1:0]  deq_valid;
   logic [31:0] deq_pc0;
   logic [31:0] deq_pc1;
   logic [31:0] deq_inst0;
   logic [31:0] deq_inst1;
   logic        deq_adel0;
   logic        deq_adel1;
   logic [1:0]  deq_num;

   modport master (
      output redirect_valid, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, deq_num,
      input  inst_req, inst_addr, deq_valid, deq_pc0, deq_pc1, deq_inst0, deq_inst1,
             deq_adel0, deq_adel1
   );

   modport slave (
      input  redirect_valid, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, deq_num,
      output inst_req, inst_addr, deq_valid, deq_pc0, deq_pc1, deq_inst0, deq_inst1,
             deq_adel0, deq_adel1
   );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: issues aligned icache requests, tracks in-flight tags, buffers returned
// instructions in an in-order queue drained by decode at up to two per cycle.
module fetch_queue #(
   parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
   parameter int unsigned QDEPTH    = 8,
   parameter int unsigned MAX_OUTST = 2
) (
   input  logic         clk,
   input  logic         rstn,
   fetch_queue_if.slave bus
);
   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned OW = $clog2(MAX_OUTST + 1);
   localparam int unsigned TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } entry_t;

   logic [31:0]   fetch_pc;
   logic          halted;
   logic [OW-1:0] outst;
   logic [OW-1:0] discard;
   logic [TW-1:0] tag_head;
   logic [31:0]   tag_q [MAX_OUTST];
   entry_t        q_mem [QDEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic          req_c;
   logic          accept;
   logic          rsp_keep;
   logic          adel_push;
   logic          misaligned;
   logic [1:0]    pop_n;
   logic [1:0]    push_n;
   entry_t        push0;
   entry_t        push1;
   logic [31:0]   rsp_tag;
   logic [TW-1:0] tag_wr;
   logic [TW-1:0] tag_head_nxt;
   logic [PW-1:0] head1;
   int unsigned   free_slots;
   int unsigned   wr_idx;
   int unsigned   rd_idx;

   // Issue decision, response routing and queue push selection.
   always_comb begin
      pop_n        = bus.redirect_valid ? 2'd0 : bus.deq_num;
      free_slots   = QDEPTH - 32'(count) + 32'(pop_n);
      misaligned   = fetch_pc[1:0] != 2'b00;
      req_c        = rstn && !bus.redirect_valid && !halted && !misaligned &&
                     (32'(outst) < MAX_OUTST) &&
                     (free_slots >= 32'd2 * (32'(outst) + 32'd1));
      accept       = req_c && bus.inst_addr_ok;
      rsp_keep     = bus.inst_data_ok && !bus.redirect_valid && (discard == '0);
      adel_push    = rstn && !bus.redirect_valid && !halted && misaligned &&
                     (outst == '0) && (discard == '0) && (free_slots >= 32'd1);
      rsp_tag      = tag_q[tag_head];
      push_n       = 2'd0;
      push0        = '0;
      push1        = '0;
      if (rsp_keep) begin
         if (!rsp_tag[2]) begin
            push0  = '{pc: rsp_tag, inst: bus.inst_rdata[31:0], adel: 1'b0};
            push1  = '{pc: rsp_tag + 32'd4, inst: bus.inst_rdata[63:32], adel: 1'b0};
            push_n = 2'd2;
         end else begin
            push0  = '{pc: rsp_tag, inst: bus.inst_rdata[63:32], adel: 1'b0};
            push_n = 2'd1;
         end
      end else if (adel_push) begin
         push0  = '{pc: fetch_pc, inst: 32'd0, adel: 1'b1};
         push_n = 2'd1;
      end
      // Live tags sit behind tag_head; discarded requests carry no tag.
      wr_idx = 32'(tag_head) + 32'(outst - discard);
      if (wr_idx >= MAX_OUTST) wr_idx = wr_idx - MAX_OUTST;
      tag_wr = TW'(wr_idx);
      rd_idx = 32'(tag_head) + 32'd1;
      if (rd_idx >= MAX_OUTST) rd_idx = rd_idx - MAX_OUTST;
      tag_head_nxt = TW'(rd_idx);
   end

   // Control state.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         fetch_pc <= RESET_PC;
         halted   <= 1'b0;
         outst    <= '0;
         discard  <= '0;
         tag_head <= '0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else if (bus.redirect_valid) begin
         fetch_pc <= bus.redirect_pc;
         halted   <= 1'b0;
         outst    <= outst - OW'(bus.inst_data_ok);
         discard  <= outst - OW'(bus.inst_data_ok);
         tag_head <= '0;
         head     <= tail;
         count    <= '0;
      end else begin
         if (accept) fetch_pc <= {fetch_pc[31:3], 3'b000} + 32'd8;
         if (adel_push) halted <= 1'b1;
         outst <= outst + OW'(accept) - OW'(bus.inst_data_ok);
         if (bus.inst_data_ok && (discard != '0)) discard <= discard - OW'(1);
         if (rsp_keep) tag_head <= tag_head_nxt;
         head  <= head + PW'(pop_n);
         tail  <= tail + PW'(push_n);
         count <= count + CW'(push_n) - CW'(pop_n);
      end
   end

   // Tag FIFO and instruction queue storage.
   always_ff @(posedge clk) begin
      if (rstn && !bus.redirect_valid) begin
         if (accept) tag_q[tag_wr] <= fetch_pc;
         if (push_n != 2'd0) q_mem[tail] <= push0;
         if (push_n == 2'd2) q_mem[tail + PW'(1)] <= push1;
      end
   end

   always_ff @(posedge clk) begin
      if (rstn && !bus.redirect_valid) begin
         a_no_underflow: assert (32'(pop_n) <= 32'(count));
         a_no_overflow:  assert (32'(count) + 32'(push_n) <= QDEPTH + 32'(pop_n));
      end
   end

   assign head1         = head + PW'(1);
   assign bus.inst_req  = req_c;
   assign bus.inst_addr = {fetch_pc[31:3], 3'b000};
   assign bus.deq_valid = {count >= CW'(2), count >= CW'(1)};
   assign bus.deq_pc0   = q_mem[head].pc;
   assign bus.deq_inst0 = q_mem[head].inst;
   assign bus.deq_adel0 = q_mem[head].adel;
   assign bus.deq_pc1   = q_mem[head1].pc;
   assign bus.deq_inst1 = q_mem[head1].inst;
   assign bus.deq_adel1 = q_mem[head1].adel;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order icache responder, queue-level reference model and
// directed scenarios (sequential fetch, redirects, fill/drain, stale drops, address error).
module tb_fetch_queue;
   logic clk;
   logic rstn;
   fetch_queue_if f ();

   fetch_queue dut (.clk(clk), .rstn(rstn), .bus(f));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {logic [31:0] pc; logic [31:0] inst; bit adel;} ent_t;
   typedef struct {logic [31:0] pc; bit stale;} fl_t;
   typedef struct {logic [31:0] addr; int due;} cr_t;

   ent_t        mq[$];
   fl_t         mf[$];
   cr_t         cq[$];
   logic [31:0] m_pc;
   bit          m_halt;
   int          n_vec, n_err, cyc, last_due;
   int          dn_mode, lat;
   bit          aok_v;

   function automatic logic [31:0] iw(input logic [31:0] a);
      return {a[15:0], ~a[31:16]};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // One clock: drive inputs, compare against model, advance cache and model.
   task automatic cycle(input bit rv, input logic [31:0] rpc);
      bit          dok, exp_req, acc, adel;
      logic [63:0] rd;
      logic [31:0] acc_addr;
      logic [1:0]  dn;
      int          free, due;
      fl_t         fh;
      dok = (cq.size() > 0) && (cq[0].due <= cyc);
      rd  = dok ? {iw(cq[0].addr + 32'd4), iw(cq[0].addr)} : 64'd0;
      dn  = (mq.size() < dn_mode) ? 2'(mq.size()) : 2'(dn_mode);
      f.redirect_valid = rv;
      f.redirect_pc    = rpc;
      f.inst_addr_ok   = aok_v;
      f.inst_data_ok   = dok;
      f.inst_rdata     = rd;
      f.deq_num        = dn;
      free    = 8 - mq.size() + (rv ? 0 : int'(dn));
      exp_req = !rv && !m_halt && (m_pc[1:0] == 2'b00) && (mf.size() < 2) &&
                (free >= 2 * (mf.size() + 1));
      #1;
      check("inst_req", 32'(f.inst_req), 32'(exp_req));
      if (exp_req) check("inst_addr", f.inst_addr, {m_pc[31:3], 3'b000});
      check("deq_valid", 32'(f.deq_valid), {30'd0, mq.size() >= 2, mq.size() >= 1});
      if (mq.size() >= 1) begin
         check("deq_pc0", f.deq_pc0, mq[0].pc);
         check("deq_inst0", f.deq_inst0, mq[0].inst);
         check("deq_adel0", 32'(f.deq_adel0), 32'(mq[0].adel));
      end
      if (mq.size() >= 2) begin
         check("deq_pc1", f.deq_pc1, mq[1].pc);
         check("deq_inst1", f.deq_inst1, mq[1].inst);
         check("deq_adel1", 32'(f.deq_adel1), 32'(mq[1].adel));
      end
      acc      = f.inst_req && aok_v;
      acc_addr = f.inst_addr;
      if (dok) void'(cq.pop_front());
      if (acc) begin
         due = cyc + lat;
         if (due < last_due) due = last_due;
         last_due = due;
         cq.push_back('{addr: acc_addr, due: due});
      end
      if (rv) begin
         if (dok && mf.size() > 0) void'(mf.pop_front());
         foreach (mf[i]) mf[i].stale = 1'b1;
         mq.delete();
         m_pc   = rpc;
         m_halt = 1'b0;
      end else begin
         adel = (m_pc[1:0] != 2'b00) && !m_halt && (mf.size() == 0) && (free >= 1);
         repeat (int'(dn)) void'(mq.pop_front());
         if (dok && mf.size() > 0) begin
            fh = mf.pop_front();
            if (!fh.stale) begin
               if (!fh.pc[2]) begin
                  mq.push_back('{pc: fh.pc, inst: iw(fh.pc), adel: 1'b0});
                  mq.push_back('{pc: fh.pc + 32'd4, inst: iw(fh.pc + 32'd4), adel: 1'b0});
               end else begin
                  mq.push_back('{pc: fh.pc, inst: iw(fh.pc), adel: 1'b0});
               end
            end
         end
         if (exp_req && aok_v) begin
            mf.push_back('{pc: m_pc, stale: 1'b0});
            m_pc = {m_pc[31:3], 3'b000} + 32'd8;
         end else if (adel) begin
            mq.push_back('{pc: m_pc, inst: 32'd0, adel: 1'b1});
            m_halt = 1'b1;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic wait_entry(input string nm, input int maxc);
      int k;
      k = 0;
      while (mq.size() == 0 && k < maxc) begin
         cycle(1'b0, 32'd0);
         k++;
      end
      if (mq.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: no queue entry within %0d cycles", nm, maxc);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      n_vec = 0; n_err = 0; cyc = 0; last_due = 0;
      dn_mode = 0; lat = 1; aok_v = 1'b1;
      rstn = 1'b0;
      f.redirect_valid = 1'b0; f.redirect_pc = 32'd0; f.inst_addr_ok = 1'b1;
      f.inst_data_ok = 1'b0; f.inst_rdata = 64'd0; f.deq_num = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_inst_req", 32'(f.inst_req), 32'd0);
      check("rst_deq_valid", 32'(f.deq_valid), 32'd0);
      m_pc = 32'hBFC0_0000; m_halt = 1'b0;
      rstn = 1'b1;
      check("t1_first_addr", f.inst_addr, 32'hBFC0_0000);

      // Sequential fetch, one-cycle cache, decode takes two per cycle.
      dn_mode = 2;
      cycle(1'b0, 32'd0);
      cycle(1'b0, 32'd0);
      check("t1_dv", 32'(f.deq_valid), 32'd3);
      check("t1_pc0", f.deq_pc0, 32'hBFC0_0000);
      check("t1_pc1", f.deq_pc1, 32'hBFC0_0004);
      check("t1_inst0", f.deq_inst0, 32'h0000_403F);
      check("t1_inst1", f.deq_inst1, 32'h0004_403F);
      repeat (10) cycle(1'b0, 32'd0);

      // Redirect into the upper half of a fetch block.
      dn_mode = 0;
      cycle(1'b1, 32'h8000_0004);
      check("t2_addr", f.inst_addr, 32'h8000_0000);
      cycle(1'b0, 32'd0);
      cycle(1'b0, 32'd0);
      check("t2_dv", 32'(f.deq_valid), 32'd1);
      check("t2_pc0", f.deq_pc0, 32'h8000_0004);
      check("t2_inst0", f.deq_inst0, 32'h0004_7FFF);
      check("t2_next_addr", f.inst_addr, 32'h8000_0010);

      // Fill with no dequeue, then drain one per cycle.
      cycle(1'b1, 32'h8000_1000);
      repeat (16) cycle(1'b0, 32'd0);
      check("t3_dv", 32'(f.deq_valid), 32'd3);
      check("t3_pc0", f.deq_pc0, 32'h8000_1000);
      check("t3_pc1", f.deq_pc1, 32'h8000_1004);
      dn_mode = 1;
      repeat (12) cycle(1'b0, 32'd0);

      // Redirect with two slow requests in flight; both responses must be dropped.
      dn_mode = 2;
      lat = 1;
      cycle(1'b1, 32'h8000_2000);
      lat = 3;
      cycle(1'b0, 32'd0);
      lat = 5;
      cycle(1'b0, 32'd0);
      cycle(1'b1, 32'h8000_3000);
      lat = 1;
      wait_entry("t4_wait", 20);
      check("t4_pc0", f.deq_pc0, 32'h8000_3000);
      check("t4_inst0", f.deq_inst0, 32'h3000_7FFF);
      repeat (6) cycle(1'b0, 32'd0);

      // Misaligned redirect: address-error entry, then halted.
      dn_mode = 0;
      cycle(1'b1, 32'h8000_0002);
      wait_entry("t5_wait", 12);
      check("t5_dv", 32'(f.deq_valid), 32'd1);
      check("t5_adel0", 32'(f.deq_adel0), 32'd1);
      check("t5_pc0", f.deq_pc0, 32'h8000_0002);
      check("t5_inst0", f.deq_inst0, 32'd0);
      repeat (5) cycle(1'b0, 32'd0);
      dn_mode = 1;
      repeat (3) cycle(1'b0, 32'd0);
      check("t5_halt_dv", 32'(f.deq_valid), 32'd0);

      // Resume with a stalling cache and mixed dequeue rates (queue pointers wrap).
      cycle(1'b1, 32'h8000_5004);
      for (int i = 0; i < 30; i++) begin
         aok_v   = (i % 3) != 1;
         dn_mode = i % 3;
         lat     = 1 + (i % 2);
         cycle(1'b0, 32'd0);
      end
      aok_v = 1'b1;
      dn_mode = 2;
      repeat (6) cycle(1'b0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
